// File: rtl/cam_pixel_capture.sv
// OV7670 RGB565 byte-stream capture: frames pixels with VSYNC/HREF, converts to
// RGB332 and writes them linearly into a dual-port frame buffer on the camera PCLK.
module cam_pixel_capture #(
  parameter int CAM_SCREEN_X = 320,
  parameter int CAM_SCREEN_Y = 240,
  parameter int AW           = 17,
  parameter int DW           = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    data,
  output logic [AW-1:0] DP_RAM_addr_in,
  output logic [DW-1:0] DP_RAM_data_in,
  output logic          DP_RAM_regW,
  output logic          frame_done,
  output logic          line_err
);

  localparam int CW = $clog2(CAM_SCREEN_X + 1);
  localparam int RW = $clog2(CAM_SCREEN_Y + 1);

  localparam logic [CW-1:0] COL_MAX   = CW'(CAM_SCREEN_X);
  localparam logic [RW-1:0] ROW_MAX   = RW'(CAM_SCREEN_Y);
  localparam logic [AW-1:0] LINE_STEP = AW'(CAM_SCREEN_X);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [RW-1:0] ROW_ONE   = RW'(1);
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

  localparam logic [2:0] S_WAIT_VS = 3'd0;
  localparam logic [2:0] S_VBLANK  = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_BYTE2   = 3'd3;
  localparam logic [2:0] S_BYTE1   = 3'd4;

  logic [2:0]    state_r, state_s;
  logic [CW-1:0] col_r, col_s;
  logic [RW-1:0] row_r, row_s;
  // Only R5[4:2] and G6[5:3] of the first byte are ever needed.
  logic [5:0]    byte1_r, byte1_s;
  logic [AW-1:0] wr_addr_r, wr_addr_s;
  logic [AW-1:0] line_base_r, line_base_s;

  logic [RW-1:0] row_inc_s;
  logic [AW-1:0] next_base_s;
  logic [7:0]    pixel_s;
  logic [AW-1:0] addr_s;
  logic [DW-1:0] data_s;
  logic          regw_s;
  logic          done_s;
  logic          err_s;

  // Pixel conversion and saturating end-of-line row/base advance.
  always_comb begin
    pixel_s = {byte1_r[5:3], byte1_r[2:0], data[4:3]};
    if (row_r < ROW_MAX) begin
      row_inc_s   = row_r + ROW_ONE;
      next_base_s = line_base_r + LINE_STEP;
    end else begin
      row_inc_s   = row_r;
      next_base_s = line_base_r;
    end
  end

  // Next-state and output decode for the capture FSM.
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    row_s       = row_r;
    byte1_s     = byte1_r;
    wr_addr_s   = wr_addr_r;
    line_base_s = line_base_r;
    addr_s      = DP_RAM_addr_in;
    data_s      = DP_RAM_data_in;
    regw_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = line_err;
    case (state_r)
      S_WAIT_VS: begin
        if (vsync) begin
          state_s = S_VBLANK;
          err_s   = 1'b0;
        end else begin
          state_s = S_WAIT_VS;
        end
      end
      S_VBLANK: begin
        col_s       = '0;
        row_s       = '0;
        wr_addr_s   = '0;
        line_base_s = '0;
        err_s       = 1'b0;
        if (!vsync) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_VBLANK;
        end
      end
      S_IDLE: begin
        if (vsync) begin
          state_s = S_VBLANK;
          done_s  = (row_r >= ROW_MAX);
          err_s   = 1'b0;
        end else if (href) begin
          byte1_s = {data[7:5], data[2:0]};
          state_s = S_BYTE2;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_BYTE2: begin
        if (vsync) begin
          // Half pixel is dropped; the interrupted line still counts.
          state_s = S_VBLANK;
          done_s  = (row_inc_s >= ROW_MAX);
          err_s   = 1'b0;
        end else if (href) begin
          state_s = S_BYTE1;
          if (col_r < COL_MAX) begin
            col_s = col_r + COL_ONE;
            if (row_r < ROW_MAX) begin
              regw_s    = 1'b1;
              addr_s    = wr_addr_r;
              data_s    = DW'(pixel_s);
              wr_addr_s = wr_addr_r + ADDR_ONE;
            end else begin
              wr_addr_s = wr_addr_r;
            end
          end else begin
            col_s = col_r;
          end
        end else begin
          state_s     = S_IDLE;
          err_s       = 1'b1;
          row_s       = row_inc_s;
          col_s       = '0;
          line_base_s = next_base_s;
          wr_addr_s   = next_base_s;
        end
      end
      S_BYTE1: begin
        if (vsync) begin
          state_s = S_VBLANK;
          done_s  = (row_inc_s >= ROW_MAX);
          err_s   = 1'b0;
        end else if (href) begin
          byte1_s = {data[7:5], data[2:0]};
          state_s = S_BYTE2;
        end else begin
          state_s     = S_IDLE;
          row_s       = row_inc_s;
          col_s       = '0;
          line_base_s = next_base_s;
          wr_addr_s   = next_base_s;
        end
      end
      default: begin
        state_s = S_WAIT_VS;
      end
    endcase
  end

  // State and registered outputs; reset forces every output low at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= S_WAIT_VS;
      col_r          <= '0;
      row_r          <= '0;
      byte1_r        <= 6'd0;
      wr_addr_r      <= '0;
      line_base_r    <= '0;
      DP_RAM_addr_in <= '0;
      DP_RAM_data_in <= '0;
      DP_RAM_regW    <= 1'b0;
      frame_done     <= 1'b0;
      line_err       <= 1'b0;
    end else begin
      state_r        <= state_s;
      col_r          <= col_s;
      row_r          <= row_s;
      byte1_r        <= byte1_s;
      wr_addr_r      <= wr_addr_s;
      line_base_r    <= line_base_s;
      DP_RAM_addr_in <= addr_s;
      DP_RAM_data_in <= data_s;
      DP_RAM_regW    <= regw_s;
      frame_done     <= done_s;
      line_err       <= err_s;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Randomized bench for cam_pixel_capture: two differently sized instances share the
// camera stream; a frame/line level model predicts every buffer write and pulse.
module tb_cam_pixel_capture;

  localparam int X0 = 4;
  localparam int Y0 = 2;
  localparam int AW0 = 3;
  localparam int X1 = 320;
  localparam int Y1 = 8;
  localparam int AW1 = 12;

  logic clk = 1'b0;
  logic rst;
  logic vsync;
  logic href;
  logic [7:0] data;

  logic [AW0-1:0] addr0;
  logic [7:0] wdata0;
  logic regw0, done0, err0;
  logic [AW1-1:0] addr1;
  logic [7:0] wdata1;
  logic regw1, done1, err1;

  cam_pixel_capture #(.CAM_SCREEN_X(X0), .CAM_SCREEN_Y(Y0), .AW(AW0), .DW(8)) dut0 (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .data(data),
    .DP_RAM_addr_in(addr0), .DP_RAM_data_in(wdata0), .DP_RAM_regW(regw0),
    .frame_done(done0), .line_err(err0)
  );

  cam_pixel_capture #(.CAM_SCREEN_X(X1), .CAM_SCREEN_Y(Y1), .AW(AW1), .DW(8)) dut1 (
    .clk(clk), .rst(rst), .vsync(vsync), .href(href), .data(data),
    .DP_RAM_addr_in(addr1), .DP_RAM_data_in(wdata1), .DP_RAM_regW(regw1),
    .frame_done(done1), .line_err(err1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  int fd_cnt0 = 0, fd_cnt1 = 0, fd_exp0 = 0, fd_exp1 = 0;
  int max0 = -1, max1 = -1;
  bit active = 1'b0;
  int lines = 0;
  bit err_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_rgb332(input logic [7:0] b1, input logic [7:0] b2);
    int v, r5, g6, b5;
    v  = int'(b1) * 256 + int'(b2);
    r5 = v / 2048;
    g6 = (v / 32) % 64;
    b5 = v % 32;
    return 8'((r5 / 4) * 32 + (g6 / 8) * 4 + b5 / 8);
  endfunction

  task automatic expect_pixel(input int row, input int col, input logic [7:0] px);
    if (row < Y0 && col < X0) q0.push_back(32'((row * X0 + col) * 256 + int'(px)));
    if (row < Y1 && col < X1) q1.push_back(32'((row * X1 + col) * 256 + int'(px)));
  endtask

  // Write monitor / scoreboard, sampled mid-cycle.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (regw0 === 1'b1) begin
        if (q0.size() == 0) check_eq("wr0_unexpected_addr", 32'(addr0), 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          check_eq("wr0_addr", 32'(addr0), e >> 8);
          check_eq("wr0_data", 32'(wdata0), e & 32'hFF);
        end
        if (int'(addr0) > max0) max0 = int'(addr0);
      end
      if (regw1 === 1'b1) begin
        if (q1.size() == 0) check_eq("wr1_unexpected_addr", 32'(addr1), 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          check_eq("wr1_addr", 32'(addr1), e >> 8);
          check_eq("wr1_data", 32'(wdata1), e & 32'hFF);
        end
        if (int'(addr1) > max1) max1 = int'(addr1);
      end
      if (done0 === 1'b1) fd_cnt0++;
      if (done1 === 1'b1) fd_cnt1++;
    end
  end

  task automatic check_outputs_zero();
    check_eq("rst_addr0", 32'(addr0), 32'd0);
    check_eq("rst_data0", 32'(wdata0), 32'd0);
    check_eq("rst_regw0", 32'(regw0), 32'd0);
    check_eq("rst_done0", 32'(done0), 32'd0);
    check_eq("rst_err0", 32'(err0), 32'd0);
    check_eq("rst_addr1", 32'(addr1), 32'd0);
    check_eq("rst_data1", 32'(wdata1), 32'd0);
    check_eq("rst_regw1", 32'(regw1), 32'd0);
    check_eq("rst_done1", 32'(done1), 32'd0);
    check_eq("rst_err1", 32'(err1), 32'd0);
  endtask

  // One line of n bytes; vs_end raises vsync while href is still high.
  task automatic send_line(input int n, input bit vs_end, input bit fixed);
    logic [7:0] b[$];
    logic [7:0] pat[4];
    pat = '{8'hF8, 8'h1F, 8'h07, 8'hE0};
    for (int i = 0; i < n; i++) b.push_back(fixed ? pat[i % 4] : 8'($urandom_range(0, 255)));
    if (active) begin
      for (int p = 0; p < n / 2; p++) expect_pixel(lines, p, to_rgb332(b[2*p], b[2*p+1]));
      if (!vs_end && (n % 2 == 1)) err_m = 1'b1;
      lines++;
    end
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      href = 1'b1;
      data = b[i];
    end
    @(posedge clk); #1;
    if (vs_end) begin
      vsync = 1'b1;
    end else begin
      href = 1'b0;
      repeat ($urandom_range(2, 4)) @(posedge clk);
      #1;
      check_eq("line_err0", 32'(err0), 32'(err_m));
      check_eq("line_err1", 32'(err1), 32'(err_m));
    end
  endtask

  task automatic vblank(input int n);
    if (active) begin
      if (lines >= Y0) fd_exp0++;
      if (lines >= Y1) fd_exp1++;
    end
    active = 1'b1;
    lines  = 0;
    err_m  = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      vsync = 1'b1;
      href  = 1'b0;
    end
    @(posedge clk); #1;
    vsync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("err_clear0", 32'(err0), 32'(err_m));
    check_eq("err_clear1", 32'(err1), 32'(err_m));
    check_eq("frame_done0", 32'(fd_cnt0), 32'(fd_exp0));
    check_eq("frame_done1", 32'(fd_cnt1), 32'(fd_exp1));
    check_eq("pending0", 32'(q0.size()), 32'd0);
    check_eq("pending1", 32'(q1.size()), 32'd0);
  endtask

  // Line interrupted by an asynchronous reset pulse after nb bytes (nb even).
  task automatic line_with_reset(input int nb, input int na);
    logic [7:0] b[$];
    for (int i = 0; i < nb; i++) b.push_back(8'($urandom_range(0, 255)));
    if (active) begin
      for (int p = 0; p < nb / 2; p++) expect_pixel(lines, p, to_rgb332(b[2*p], b[2*p+1]));
    end
    for (int i = 0; i < nb; i++) begin
      @(posedge clk); #1;
      href = 1'b1;
      data = b[i];
    end
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero();
    #1;
    rst = 1'b1;
    active = 1'b0;
    lines  = 0;
    err_m  = 1'b0;
    for (int i = 0; i < na; i++) begin
      @(posedge clk); #1;
      href = 1'b1;
      data = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    href = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nl;
    rst = 1'b0;
    vsync = 1'b0;
    href = 1'b0;
    data = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero();
    rst = 1'b1;

    send_line(6, 1'b0, 1'b0);
    vblank(3);
    send_line(8, 1'b0, 1'b1);
    send_line(8, 1'b0, 1'b1);
    vblank(3);

    send_line(12, 1'b0, 1'b0);
    send_line(8, 1'b0, 1'b0);
    vblank(3);

    send_line(7, 1'b0, 1'b0);
    send_line(8, 1'b0, 1'b0);
    vblank(3);

    send_line(5, 1'b1, 1'b0);
    vblank(3);
    send_line(8, 1'b0, 1'b0);
    send_line(8, 1'b0, 1'b0);
    vblank(3);

    for (int f = 0; f < 6; f++) begin
      nl = $urandom_range(1, 4);
      for (int l = 0; l < nl; l++)
        send_line($urandom_range(1, 14), (l == nl - 1) && ($urandom_range(0, 1) == 1), 1'b0);
      vblank($urandom_range(1, 4));
    end

    send_line(8, 1'b0, 1'b0);
    line_with_reset(4, 5);
    send_line(8, 1'b0, 1'b0);
    vblank(3);
    send_line(8, 1'b0, 1'b0);
    send_line(8, 1'b0, 1'b0);
    vblank(3);

    for (int l = 0; l < 9; l++) send_line(644, 1'b0, 1'b0);
    vblank(3);

    check_eq("max_addr0", 32'(max0), 32'(X0 * Y0 - 1));
    check_eq("max_addr1", 32'(max1), 32'(X1 * Y1 - 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
